// File: rtl/cpu_sequencer.sv
// Instruction sequencer: prescaled fetch/execute control for a 4-bit CPU.
// Fetches from an acked ROM, hands the instruction to an external ALU, commits its result.
package cpu_pkg;
  typedef logic [3:0] opecode_t;
  typedef struct packed {
    logic [3:0] a;
    logic [3:0] b;
    logic [3:0] out;
    logic [3:0] ip;
    logic       carry;
  } regs_t;
endpackage

module cpu_sequencer
  import cpu_pkg::*;
#(
  parameter int unsigned PRESCALE    = 4,
  parameter int unsigned ACK_TIMEOUT = 8
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       run,
  input  logic       step,
  output logic       rom_req,
  output logic [3:0] rom_addr,
  input  logic       rom_ack,
  input  logic [7:0] rom_data,
  output opecode_t   alu_opecode,
  output logic [3:0] alu_imm,
  output regs_t      alu_current,
  input  regs_t      alu_next,
  output regs_t      regs,
  output logic       busy,
  output logic       fault
);

  typedef enum logic [1:0] {
    IDLE,
    FETCH,
    EXEC,
    FAULT
  } state_t;

  localparam logic [16:0] PRE_LAST  = 17'(PRESCALE - 1);
  localparam logic [15:0] WAIT_LAST = 16'(ACK_TIMEOUT - 1);

  state_t      state_q, state_d;
  regs_t       regs_q, regs_d;
  logic [7:0]  ir_q, ir_d;
  logic [16:0] pre_q, pre_d;
  logic [15:0] wait_q, wait_d;
  logic        tick;

  assign tick = (pre_q == PRE_LAST);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      regs_q  <= '0;
      ir_q    <= '0;
      pre_q   <= '0;
      wait_q  <= '0;
    end else begin
      state_q <= state_d;
      regs_q  <= regs_d;
      ir_q    <= ir_d;
      pre_q   <= pre_d;
      wait_q  <= wait_d;
    end
  end

  always_comb begin
    state_d = state_q;
    regs_d  = regs_q;
    ir_d    = ir_q;
    pre_d   = pre_q;
    wait_d  = wait_q;
    if (state_q != FAULT) begin
      pre_d = tick ? '0 : pre_q + 17'd1;
    end
    unique case (state_q)
      IDLE: begin
        wait_d = '0;
        if ((run && tick) || (!run && step)) begin
          state_d = FETCH;
        end
      end
      FETCH: begin
        if (rom_ack) begin
          ir_d    = rom_data;
          wait_d  = '0;
          state_d = EXEC;
        end else if (wait_q == WAIT_LAST) begin
          state_d = FAULT;
        end else begin
          wait_d = wait_q + 16'd1;
        end
      end
      EXEC: begin
        regs_d  = alu_next;
        state_d = IDLE;
      end
      FAULT: begin
        state_d = FAULT;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // Outputs decode straight from the state flop so reset clears them at once.
  assign rom_req     = (state_q == FETCH);
  assign rom_addr    = regs_q.ip;
  assign alu_opecode = ir_q[7:4];
  assign alu_imm     = ir_q[3:0];
  assign alu_current = regs_q;
  assign regs        = regs_q;
  assign busy        = (state_q == FETCH) || (state_q == EXEC);
  assign fault       = (state_q == FAULT);

endmodule

// File: tb/tb_cpu_sequencer.sv
// Bench for cpu_sequencer: ROM and ALU models plus a commit scoreboard.
module tb_cpu_sequencer;
  import cpu_pkg::*;

  localparam int PRE = 4;
  localparam int TMO = 8;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       run = 1'b0;
  logic       step = 1'b0;
  logic       rom_req;
  logic [3:0] rom_addr;
  logic       rom_ack;
  logic [7:0] rom_data;
  opecode_t   alu_opecode;
  logic [3:0] alu_imm;
  regs_t      alu_current;
  regs_t      alu_next;
  regs_t      regs;
  logic       busy;
  logic       fault;

  logic [7:0] mem [16];
  logic       ack_en = 1'b0;
  logic       ack_force = 1'b0;
  int         cyc = 0;
  int         total = 0;
  int         bad = 0;
  regs_t      exp_q [$];
  regs_t      last_exp;

  cpu_sequencer #(.PRESCALE(PRE), .ACK_TIMEOUT(TMO)) dut (
    .clk(clk), .rst_n(rst_n), .run(run), .step(step),
    .rom_req(rom_req), .rom_addr(rom_addr),
    .rom_ack(rom_ack), .rom_data(rom_data),
    .alu_opecode(alu_opecode), .alu_imm(alu_imm),
    .alu_current(alu_current), .alu_next(alu_next),
    .regs(regs), .busy(busy), .fault(fault)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  assign rom_ack  = (rom_req & ack_en) | ack_force;
  assign rom_data = mem[rom_addr];

  // TD4-style ALU: 0 ADD A,imm; 3 MOV A,imm; F JMP imm; others nop.
  always_comb begin
    alu_next       = alu_current;
    alu_next.ip    = alu_current.ip + 4'd1;
    alu_next.carry = 1'b0;
    case (alu_opecode)
      4'h0: {alu_next.carry, alu_next.a} =
              {1'b0, alu_current.a} + {1'b0, alu_imm};
      4'h3: alu_next.a = alu_imm;
      4'hF: alu_next.ip = alu_imm;
      default: ;
    endcase
  end

  task automatic do_reset();
    rst_n = 1'b0;
    run = 1'b0;
    step = 1'b0;
    ack_force = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic step_pulse();
    @(negedge clk);
    step = 1'b1;
    @(negedge clk);
    step = 1'b0;
  endtask

  task automatic wait_exec(input int budget, input bit jit, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < budget; i++) begin
      @(negedge clk);
      if (jit) step = 1'($urandom_range(0, 1));
      if (busy && !rom_req) begin
        ok = 1'b1;
        break;
      end
    end
    step = 1'b0;
  endtask

  task automatic test_reset();
    do_reset();
    @(negedge clk);
    total++;
    if (regs !== regs_t'(0)) begin
      bad++; $display("FAIL reset_regs got=%h exp=0", regs);
    end
    total++;
    if ({busy, fault, rom_req} !== 3'b000) begin
      bad++; $display("FAIL reset_flags got=%b exp=000", {busy, fault, rom_req});
    end
    total++;
    if ({alu_opecode, alu_imm} !== 8'h00) begin
      bad++; $display("FAIL reset_ir got=%h exp=00", {alu_opecode, alu_imm});
    end
  endtask

  task automatic test_step();
    regs_t e, got;
    mem[0] = 8'h35;
    ack_en = 1'b1;
    e = '{a: 4'd5, b: 4'd0, out: 4'd0, ip: 4'd1, carry: 1'b0};
    exp_q.push_back(e);
    step_pulse();
    total++;
    if ({rom_req, busy, rom_addr} !== 6'b110000) begin
      bad++; $display("FAIL step_fetch got=%b exp=110000", {rom_req, busy, rom_addr});
    end
    @(negedge clk);
    total++;
    if ({rom_req, busy, alu_opecode, alu_imm} !== 10'b01_0011_0101) begin
      bad++; $display("FAIL step_exec got=%b exp=0100110101",
                      {rom_req, busy, alu_opecode, alu_imm});
    end
    total++;
    if (regs !== regs_t'(0)) begin
      bad++; $display("FAIL step_early got=%h exp=0", regs);
    end
    @(negedge clk);
    got = exp_q.pop_front();
    last_exp = got;
    total++;
    if (regs !== got) begin
      bad++; $display("FAIL step_commit got=%h exp=%h", regs, got);
    end
    total++;
    if ({busy, alu_opecode, alu_imm} !== 9'b0_0011_0101) begin
      bad++; $display("FAIL step_idle got=%b exp=000110101", {busy, alu_opecode, alu_imm});
    end
  endtask

  task automatic test_ip_wrap();
    regs_t e;
    bit ok;
    mem[1] = 8'hFF;
    mem[15] = 8'h80;
    exp_q.push_back('{a: 4'd5, b: 4'd0, out: 4'd0, ip: 4'd15, carry: 1'b0});
    exp_q.push_back('{a: 4'd5, b: 4'd0, out: 4'd0, ip: 4'd0, carry: 1'b0});
    exp_q.push_back('{a: 4'd5, b: 4'd0, out: 4'd0, ip: 4'd1, carry: 1'b0});
    for (int k = 0; k < 3; k++) begin
      step_pulse();
      if (k == 2) begin
        total++;
        if ({rom_req, rom_addr} !== 5'b10000) begin
          bad++; $display("FAIL wrap_addr got=%b exp=10000", {rom_req, rom_addr});
        end
      end
      wait_exec(4, 1'b0, ok);
      total++;
      if (!ok) begin
        bad++; $display("FAIL wrap_exec_timeout k=%0d got=0 exp=1", k);
      end
      if (k == 1) begin
        total++;
        if (alu_opecode !== 4'h8) begin
          bad++; $display("FAIL wrap_op got=%h exp=8", alu_opecode);
        end
      end
      @(negedge clk);
      e = exp_q.pop_front();
      last_exp = e;
      total++;
      if (regs !== e) begin
        bad++; $display("FAIL wrap_commit k=%0d got=%h exp=%h", k, regs, e);
      end
    end
  endtask

  task automatic test_run();
    regs_t m, e;
    bit ok;
    bit seen;
    int t0, tl;
    logic [4:0] sum;
    mem[0] = 8'h01;
    mem[1] = 8'hF0;
    ack_en = 1'b1;
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    run = 1'b1;
    rst_n = 1'b1;
    t0 = cyc;
    tl = 0;
    m = '0;
    for (int i = 0; i < 34; i++) begin
      if (m.ip == 4'd0) begin
        sum = {1'b0, m.a} + 5'd1;
        m.a = sum[3:0];
        m.carry = sum[4];
        m.ip = 4'd1;
      end else begin
        m.ip = 4'd0;
        m.carry = 1'b0;
      end
      exp_q.push_back(m);
      wait_exec(12, 1'b1, ok);
      total++;
      if (!ok) begin
        bad++; $display("FAIL run_exec_timeout i=%0d got=0 exp=1", i);
      end
      total++;
      if (i == 0 && (cyc - t0) != PRE + 1) begin
        bad++; $display("FAIL run_first_tick got=%0d exp=%0d", cyc - t0, PRE + 1);
      end else if (i > 0 && (cyc - tl) != PRE) begin
        bad++; $display("FAIL run_period i=%0d got=%0d exp=%0d", i, cyc - tl, PRE);
      end
      tl = cyc;
      @(negedge clk);
      e = exp_q.pop_front();
      total++;
      if (regs !== e) begin
        bad++; $display("FAIL run_commit i=%0d got=%h exp=%h", i, regs, e);
      end
    end
    seen = 1'b0;
    for (int i = 0; i < 8 && !seen; i++) begin
      @(negedge clk);
      seen = rom_req;
    end
    run = 1'b0;
    sum = {1'b0, m.a} + 5'd1;
    m.a = sum[3:0];
    m.carry = sum[4];
    m.ip = 4'd1;
    exp_q.push_back(m);
    wait_exec(4, 1'b0, ok);
    @(negedge clk);
    e = exp_q.pop_front();
    last_exp = e;
    total++;
    if (!seen || !ok || regs !== e) begin
      bad++; $display("FAIL run_stop_commit got=%h exp=%h", regs, e);
    end
    seen = 1'b0;
    repeat (12) begin
      @(negedge clk);
      seen = seen | busy;
    end
    total++;
    if (seen || regs !== last_exp) begin
      bad++; $display("FAIL run_stays_idle got=%b/%h exp=0/%h", seen, regs, last_exp);
    end
  endtask

  task automatic test_timeout();
    int n;
    bit seen;
    ack_en = 1'b0;
    step_pulse();
    n = 0;
    for (int k = 0; k < 20; k++) begin
      if (!rom_req) break;
      n++;
      @(negedge clk);
    end
    total++;
    if (n != TMO) begin
      bad++; $display("FAIL tmo_cycles got=%0d exp=%0d", n, TMO);
    end
    total++;
    if ({fault, rom_req, busy} !== 3'b100) begin
      bad++; $display("FAIL tmo_flags got=%b exp=100", {fault, rom_req, busy});
    end
    total++;
    if (regs !== last_exp) begin
      bad++; $display("FAIL tmo_regs got=%h exp=%h", regs, last_exp);
    end
    ack_en = 1'b1;
    step_pulse();
    run = 1'b1;
    seen = 1'b0;
    repeat (20) begin
      @(negedge clk);
      seen = seen | rom_req | busy;
    end
    run = 1'b0;
    total++;
    if (seen || fault !== 1'b1 || regs !== last_exp) begin
      bad++; $display("FAIL tmo_sticky got=%b%b/%h exp=01/%h", seen, fault, regs, last_exp);
    end
  endtask

  task automatic test_reset_fetch();
    do_reset();
    ack_en = 1'b0;
    step_pulse();
    total++;
    if (rom_req !== 1'b1) begin
      bad++; $display("FAIL rf_req got=%b exp=1", rom_req);
    end
    #1 rst_n = 1'b0;
    #1;
    total++;
    if ({rom_req, busy, fault} !== 3'b000 || regs !== regs_t'(0)) begin
      bad++; $display("FAIL rf_async got=%b/%h exp=000/0", {rom_req, busy, fault}, regs);
    end
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    ack_force = 1'b1;
    @(negedge clk);
    ack_force = 1'b0;
    @(negedge clk);
    total++;
    if ({rom_req, busy, alu_opecode} !== 6'b0 || regs !== regs_t'(0)) begin
      bad++; $display("FAIL rf_late_ack got=%b/%h exp=0/0",
                      {rom_req, busy, alu_opecode}, regs);
    end
  endtask

  initial begin
    for (int i = 0; i < 16; i++) mem[i] = 8'h80;
    test_reset();
    test_step();
    test_ip_wrap();
    test_run();
    test_timeout();
    test_reset_fetch();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/cpu_sequencer.md
CPU_SEQUENCER -- requirements
Module: cpu_sequencer

Interface
REQ-001 Parameters: PRESCALE, 4, clock cycles per instruction-start tick (1..2^16); ACK_TIMEOUT, 8, cycles allowed for a ROM ack before fault.
REQ-002 Port: clk  in  1  sole clock; all state updates on its rising edge.
REQ-003 Port: rst_n  in  1  reset; asynchronous, active-low.
REQ-004 Port: run  in  1  level; 1 = free-running execution.
REQ-005 Port: step  in  1  single-cycle pulse; executes one instruction when run=0.
REQ-006 Port: rom_req  out  1  fetch request, held until ack.
REQ-007 Port: rom_addr  out  4  fetch address (current ip).
REQ-008 Port: rom_ack  in  1  fetch data valid this cycle.
REQ-009 Port: rom_data  in  8  instruction; [7:4] opecode, [3:0] imm.
REQ-010 Port: alu_opecode  out  OPECODE  decoded opecode to ALU.
REQ-011 Port: alu_imm  out  4  immediate to ALU.
REQ-012 Port: alu_current  out  REGS  architectural state to ALU.
REQ-013 Port: alu_next  in  REGS  ALU result state.
REQ-014 Port: regs  out  REGS  committed state (a, b, out, ip, carry).
REQ-015 Port: busy  out  1  high in any state except IDLE and FAULT.
REQ-016 Port: fault  out  1  sticky ROM-timeout flag.

Function
REQ-017 States: IDLE, FETCH, EXEC, FAULT.
REQ-018 Prescaler counts 0..PRESCALE-1, wraps to 0; tick = 1 when count = PRESCALE-1; counts freely in all states except FAULT.
REQ-019 IDLE -> FETCH when (run=1 and tick=1) or (run=0 and step=1); step with run=1 ignored; step outside IDLE ignored (not queued).
REQ-020 FETCH: rom_req=1, rom_addr=regs.ip; on rom_ack=1 latch rom_data into instruction register, drop rom_req next cycle, go EXEC.
REQ-021 FETCH timeout: ack-wait counter reaches ACK_TIMEOUT with no ack -> FAULT, fault=1, rom_req=0, regs unchanged.
REQ-022 rom_ack outside FETCH ignored.
REQ-023 EXEC lasts exactly one cycle: alu_opecode/alu_imm from instruction register, alu_current=regs; at end of cycle regs <= alu_next; go IDLE.
REQ-024 alu_opecode/alu_imm hold last latched instruction outside EXEC; alu_current always equals regs.
REQ-025 Latency: step pulse to regs update = 1 (FETCH entry) + ack latency + 1 (EXEC) cycles; ack in first FETCH cycle gives regs update 3 cycles after step sample.
REQ-026 Unrecognised opecode values pass through unchanged; ALU treats them as nop; sequencer adds no decode filtering.
REQ-027 ip wrap (15 -> 0) is solely the ALU's result; sequencer commits alu_next.ip verbatim.
REQ-028 run deasserted mid-instruction: current instruction completes; stays IDLE afterwards.
REQ-029 FAULT exits only via reset; run/step ignored in FAULT.

Reset
REQ-030 rst_n=0 asynchronously forces: state IDLE, regs all-zero (a=b=out=ip=0, carry=0), instruction register 0, prescaler 0, ack-wait counter 0, rom_req=0, busy=0, fault=0.
REQ-031 Reset asserted mid-FETCH drops rom_req immediately without awaiting clock; a late rom_ack after release is ignored.
REQ-032 First tick after reset release occurs PRESCALE cycles after the first clock edge with rst_n=1.

Verification
REQ-033 run=0, step pulse, ROM[0]=0x35 (MOV_A_IMM imm 5), ack same cycle -> 3 cycles later regs.a=5, regs.ip=1, busy back to 0.
REQ-034 run=1, PRESCALE=4, ROM all ack-immediately, ADD_A_IMM 1 loop with JMP_IMM 0 -> one instruction start every 4 cycles, a increments per pass, carry set on 15->0.
REQ-035 step pulse, rom_ack never asserted, ACK_TIMEOUT=8 -> fault=1 after 8 FETCH cycles, rom_req=0, regs unchanged; subsequent step/run ignored until rst_n low.
REQ-036 rst_n low during FETCH with rom_req=1 -> rom_req=0 and all regs 0 before next clock edge; ack pulse after release leaves state IDLE.
REQ-037 run=1 with step pulses during FETCH/EXEC -> no extra instructions executed; instruction count equals tick count.
REQ-038 ip=15 executing a non-jump instruction -> regs.ip=0 committed, next fetch address 0.
